dmem_responder: RTL and testbench

- Data-memory responder for the single-cycle datapath's load/store port.
- Accepts one request at a time from the datapath (initiator) over a valid/ready handshake.
- Performs RV32I byte/half/word loads and stores against an internal word array, with a configurable number of wait states.
- Returns load data, already sign- or zero-extended, on a separate response channel.

---
 rtl/dmem_responder.sv | 190 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready request at a time, RV32I byte/half/word access
// after WAIT_CYCLES wait states. Optional access-fault reporting under `DMEM_ERR_EN.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        be;
  logic [31:0]       wdata_al;
  logic [31:0]       rd_word, rd_ext;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic              fault;
  logic              access;

  // Address bits above the array are intentionally dropped (wrap).
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign idx    = addr_q[ADDR_W+1:2];
  assign access = (state_q == StBusy) && (cnt_q == 4'd0);

`ifdef DMEM_ERR_EN
  always_comb begin
    fault = 1'b0;
    unique case (funct3_q)
      3'b000:  fault = 1'b0;
      3'b001:  fault = addr_q[0];
      3'b010:  fault = |addr_q[1:0];
      3'b100:  fault = we_q;
      3'b101:  fault = we_q | addr_q[0];
      default: fault = 1'b1;
    endcase
  end
`else
  assign fault = 1'b0;
`endif

  // Store lane enables and replicated store data; misaligned low bits fall away here.
  always_comb begin
    be       = 4'b1111;
    wdata_al = wdata_q;
    case (funct3_q)
      3'b000: begin
        be       = 4'b0001 << addr_q[1:0];
        wdata_al = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_word = mem[idx];
    rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = rd_word;
    endcase
    if (we_q || fault) rd_ext = 32'd0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr[ADDR_W+1:0];
          we_d        = req_we;
          wdata_d     = req_wdata;
          funct3_d    = req_funct3;
          cnt_d       = 4'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = StBusy;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_ext;
          rsp_err_d   = fault;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      funct3_q    <= 3'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is not reset; reset forces StIdle, so a pending store never reaches its access edge.
  always_ff @(posedge clk) begin
    if (access && we_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef DMEM_ERR_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=8, WAIT_CYCLES=1); covers both DMEM_ERR_EN builds.
module tb_dmem_responder;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned WAIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_funct3 = f3;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WAIT_CYCLES + 1));
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
    present(we, addr, wd, f3);
    wait_rsp(tag);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    handshake(tag);
  endtask

  initial begin
    // Reset held with clock running
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    chk("release_ready_after_edge", 32'(req_ready), 32'd1);

    access("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    access("lw_10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Reset while the store is still in BUSY
    present(1'b1, 32'h10, 32'h11111111, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) tick();
    chk("midrst_rsp_valid_hold", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    access("midrst_lw_10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    access("sb_13", 1'b1, 32'h13, 32'h00000080, 3'b000, 32'h0, 1'b0);
    access("lb_13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    access("lbu_13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0);
    access("lw_10_sb", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 1'b0);

    access("sh_12", 1'b1, 32'h12, 32'h00001234, 3'b001, 32'h0, 1'b0);
    access("lhu_12", 1'b0, 32'h12, 32'h0, 3'b101, 32'h00001234, 1'b0);
    access("lh_10", 1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    access("lw_10_sh", 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234BEEF, 1'b0);
    access("lw_410_wrap", 1'b0, 32'h410, 32'h0, 3'b010, 32'h1234BEEF, 1'b0);

    // Back-pressure in RESP, with a stray store request that must be ignored
    present(1'b0, 32'h10, 32'h0, 3'b010);
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        req_funct3 = 3'b010;
      end
      tick();
      req_valid = 1'b0;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1234BEEF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    handshake("bp");
    access("bp_lw_10_after", 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234BEEF, 1'b0);

`ifdef DMEM_ERR_EN
    access("lw_11_mis", 1'b0, 32'h11, 32'h0, 3'b010, 32'h0, 1'b1);
    access("sw_12_mis", 1'b1, 32'h12, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1);
    access("lw_10_after_mis", 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234BEEF, 1'b0);
`else
    access("lw_11_mis", 1'b0, 32'h11, 32'h0, 3'b010, 32'h1234BEEF, 1'b0);
    access("sw_12_mis", 1'b1, 32'h12, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b0);
    access("lw_10_after_mis", 1'b0, 32'h10, 32'h0, 3'b010, 32'hFFFFFFFF, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
